// File: rtl/fe_capture_pkg.sv
// Shared FIFO command codes, field widths and capture FSM state encoding
// for the front-end USB sniff capture path.
package fe_capture_pkg;

  localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
  localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

  localparam int FE_CMD_W  = 2;
  localparam int FE_DATA_W = 8;
  localparam int FE_STAT_W = 5;
  localparam int FE_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } fe_state_t;

endpackage

// File: rtl/fe_capture_skid.sv
// Two-entry in-order skid queue with bypass. Each cycle it accepts up to two
// new entries (in0 first, then in1) and presents exactly one entry for output:
// the oldest queued entry if any, otherwise in0. Whatever is not presented is
// stored. A TIME+event pair can only be produced after a long idle gap, by
// which point the queue has drained, so occupancy stays within two.
module fe_capture_skid #(
  parameter int W = 8
) (
  input  logic         fe_clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [1:0]   in_cnt,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic         out_vld,
  output logic [W-1:0] out_d
);

  logic [1:0][W-1:0] q;
  logic [1:0]        occ;

  // Present the oldest entry: queued head first, else the bypassed new entry.
  always_comb begin
    out_vld = (occ != 2'd0) || (in_cnt != 2'd0);
    out_d   = (occ != 2'd0) ? q[0] : in0;
  end

  // Store whatever was not presented this cycle, preserving order.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      occ <= 2'd0;
      q   <= '0;
    end else if (flush) begin
      occ <= 2'd0;
      q   <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (in_cnt == 2'd2) begin
            q[0] <= in1;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (in_cnt != 2'd0) q[0] <= in0;
          if (in_cnt == 2'd2) begin
            q[1] <= in1;
            occ  <= 2'd2;
          end else if (in_cnt == 2'd0) begin
            occ <= 2'd0;
          end
        end
        default: begin
          q[0] <= q[1];
          if (in_cnt != 2'd0) q[1] <= in0;
          else                occ  <= 2'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fe_capture.sv
// Front-end capture: turns sniffed USB bytes and line-status changes into
// DATA/STAT/TIME FIFO entries with delta timestamps.
// Optional feature: define PW_STAT_EVENTS_EN to emit STAT entries on status
// changes that are not accompanied by a data byte.
module fe_capture
  import fe_capture_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3
) (
  input  logic                             fe_clk,
  input  logic                             reset_n,
  input  logic                             I_arm,
  input  logic                             I_match,
  input  logic                             I_timestamps_disable,
  input  logic [FE_LEN_W-1:0]              I_capture_len,
  input  logic                             I_fifo_full,
  input  logic [FE_DATA_W-1:0]             I_data,
  input  logic                             I_data_valid,
  input  logic [FE_STAT_W-1:0]             I_stat,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_capture_time,
  output logic [FE_DATA_W-1:0]             O_capture_data,
  output logic [FE_STAT_W-1:0]             O_capture_stat,
  output logic [FE_CMD_W-1:0]              O_capture_cmd,
  output logic                             O_capture_data_wr,
  output logic                             O_capturing,
  output logic                             O_done,
  output logic                             O_overflow
);

  localparam int TW = pTIMESTAMP_FULL_WIDTH;
  localparam int SW = pTIMESTAMP_SHORT_WIDTH;
  localparam logic [TW-1:0] SHORT_MAX = TW'((1 << SW) - 1);
  localparam logic [TW-1:0] FULL_MAX  = '1;

  typedef struct packed {
    logic [FE_CMD_W-1:0]  cmd;
    logic [TW-1:0]        ts;
    logic [FE_DATA_W-1:0] data;
    logic [FE_STAT_W-1:0] stat;
  } entry_t;

  localparam int EW = $bits(entry_t);

  fe_state_t           state, state_nxt;
  logic                arm_q;
  logic [TW-1:0]       dcnt;
  logic [FE_LEN_W-1:0] len_q, gen_cnt, out_cnt;
  logic                arm_rise, cap_act, stop, ts_en;
  logic                ev_data, ev_stat, ev, need_time, wrap_time, done_hit;
  logic [1:0]          sk_in_cnt;
  entry_t              ev_e, time_e, sk_in0, out_e;
  logic                sk_out_vld;
  logic [EW-1:0]       sk_out_d;

`ifdef PW_STAT_EVENTS_EN
  logic [FE_STAT_W-1:0] stat_q;

  // Previous-cycle status, for change detection.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) stat_q <= '0;
    else          stat_q <= I_stat;
  end
`endif

  // Event detection and entry formation for the current cycle.
  always_comb begin
    arm_rise  = I_arm & ~arm_q;
    cap_act   = (state == ST_CAPTURE) && !arm_rise;
    stop      = (len_q != '0) && (gen_cnt == len_q);
    ts_en     = !I_timestamps_disable;
    ev_data   = cap_act && !stop && I_data_valid;
`ifdef PW_STAT_EVENTS_EN
    ev_stat   = cap_act && !stop && !I_data_valid && (I_stat != stat_q);
`else
    ev_stat   = 1'b0;
`endif
    ev        = ev_data || ev_stat;
    need_time = ts_en && ev && (dcnt > SHORT_MAX);
    wrap_time = ts_en && cap_act && !stop && !ev && (dcnt == FULL_MAX);

    ev_e.cmd  = ev_data ? FE_FIFO_CMD_DATA : FE_FIFO_CMD_STAT;
    ev_e.ts   = (ts_en && !need_time) ? {{(TW-SW){1'b0}}, dcnt[SW-1:0]} : '0;
    ev_e.data = ev_data ? I_data : '0;
    ev_e.stat = I_stat;

    time_e.cmd  = FE_FIFO_CMD_TIME;
    time_e.ts   = dcnt;
    time_e.data = '0;
    time_e.stat = '0;

    // A TIME entry always precedes the event it belongs to.
    sk_in_cnt = need_time ? 2'd2 : ((ev || wrap_time) ? 2'd1 : 2'd0);
    sk_in0    = (need_time || wrap_time) ? time_e : ev_e;

    out_e    = entry_t'(sk_out_d);
    done_hit = cap_act && sk_out_vld && (out_e.cmd == FE_FIFO_CMD_DATA) &&
               (len_q != '0) && ((out_cnt + 16'd1) == len_q);
  end

  fe_capture_skid #(.W(EW)) u_skid (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .flush   (arm_rise),
    .in_cnt  (sk_in_cnt),
    .in0     (sk_in0),
    .in1     (ev_e),
    .out_vld (sk_out_vld),
    .out_d   (sk_out_d)
  );

  // State register.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an arm rising edge wins from any state.
  always_comb begin
    state_nxt = state;
    if (arm_rise) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED:   if (I_match)  state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (done_hit) state_nxt = ST_DONE;
        default:    state_nxt = state;
      endcase
    end
  end

  // Arm edge detector and capture counters. arm_q resets high so that an arm
  // level already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q   <= 1'b1;
      dcnt    <= '0;
      len_q   <= '0;
      gen_cnt <= '0;
      out_cnt <= '0;
    end else begin
      arm_q <= I_arm;
      if (arm_rise) begin
        dcnt    <= '0;
        gen_cnt <= '0;
        out_cnt <= '0;
      end else if (state == ST_ARMED && I_match) begin
        len_q   <= I_capture_len;
        dcnt    <= '0;
        gen_cnt <= '0;
        out_cnt <= '0;
      end else if (cap_act) begin
        dcnt <= (ev || wrap_time) ? '0 : dcnt + TW'(1);
        if (ev_data) gen_cnt <= gen_cnt + 16'd1;
        if (sk_out_vld && out_e.cmd == FE_FIFO_CMD_DATA) out_cnt <= out_cnt + 16'd1;
      end
    end
  end

  // Registered FIFO write port; a full FIFO drops the entry and flags overflow.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      O_capture_data_wr <= 1'b0;
      O_capture_cmd     <= '0;
      O_capture_time    <= '0;
      O_capture_data    <= '0;
      O_capture_stat    <= '0;
      O_overflow        <= 1'b0;
    end else begin
      O_capture_data_wr <= 1'b0;
      if (arm_rise) begin
        O_overflow <= 1'b0;
      end else if (cap_act && sk_out_vld) begin
        if (I_fifo_full) begin
          O_overflow <= 1'b1;
        end else begin
          O_capture_data_wr <= 1'b1;
          O_capture_cmd     <= out_e.cmd;
          O_capture_time    <= out_e.ts;
          O_capture_data    <= out_e.data;
          O_capture_stat    <= out_e.stat;
        end
      end
    end
  end

  assign O_capturing = (state == ST_CAPTURE);
  assign O_done      = (state == ST_DONE);

endmodule

// File: tb/tb_fe_capture.sv
// Directed bench for fe_capture with hand-computed expectations.
module tb_fe_capture;

  logic        fe_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        I_arm = 1'b0, I_match = 1'b0, I_timestamps_disable = 1'b0;
  logic [15:0] I_capture_len = '0;
  logic        I_fifo_full = 1'b0;
  logic [7:0]  I_data = '0;
  logic        I_data_valid = 1'b0;
  logic [4:0]  I_stat = '0;
  logic [15:0] O_capture_time;
  logic [7:0]  O_capture_data;
  logic [4:0]  O_capture_stat;
  logic [1:0]  O_capture_cmd;
  logic        O_capture_data_wr, O_capturing, O_done, O_overflow;

  int passed = 0;
  int total  = 0;
  int nwr, at;
  logic [15:0] tsv;
  logic [1:0]  cmdv;

  localparam logic [1:0] C_DATA = 2'd0, C_STAT = 2'd1, C_TIME = 2'd2;

  always #5 fe_clk = ~fe_clk;

  fe_capture dut (
    .fe_clk (fe_clk), .reset_n (reset_n), .I_arm (I_arm), .I_match (I_match),
    .I_timestamps_disable (I_timestamps_disable), .I_capture_len (I_capture_len),
    .I_fifo_full (I_fifo_full), .I_data (I_data), .I_data_valid (I_data_valid),
    .I_stat (I_stat), .O_capture_time (O_capture_time), .O_capture_data (O_capture_data),
    .O_capture_stat (O_capture_stat), .O_capture_cmd (O_capture_cmd),
    .O_capture_data_wr (O_capture_data_wr), .O_capturing (O_capturing),
    .O_done (O_done), .O_overflow (O_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] cmd, input logic [15:0] ts,
                        input logic [7:0] data);
    chk({tag, ".wr"},   32'(O_capture_data_wr), 32'd1);
    chk({tag, ".cmd"},  32'(O_capture_cmd),     32'(cmd));
    chk({tag, ".time"}, 32'(O_capture_time),    32'(ts));
    chk({tag, ".data"}, 32'(O_capture_data),    32'(data));
  endtask

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic idle_count(input int n, output int w);
    w = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      w += int'(O_capture_data_wr);
    end
  endtask

  initial begin
    // Reset state, arm already high when reset releases.
    I_stat = 5'h04;
    I_arm  = 1'b1;
    #23;
    chk("rst.wr",   32'(O_capture_data_wr), 32'd0);
    chk("rst.cap",  32'(O_capturing),       32'd0);
    chk("rst.done", 32'(O_done),            32'd0);
    chk("rst.ovf",  32'(O_overflow),        32'd0);
    chk("rst.time", 32'(O_capture_time),    32'd0);
    @(negedge fe_clk) reset_n = 1'b1;
    tick();
    I_match = 1'b1; tick();
    I_match = 1'b0; tick();
    chk("norelarm.cap", 32'(O_capturing), 32'd0);

    // Three back-to-back data bytes, len=3.
    I_arm = 1'b0; tick();
    I_arm = 1'b1; tick();
    I_capture_len = 16'd3; I_match = 1'b1; tick();
    chk("l3.cap", 32'(O_capturing), 32'd1);
    I_match = 1'b0; I_data_valid = 1'b1; I_data = 8'hA5; tick();
    chk_wr("l3.d0", C_DATA, 16'd0, 8'hA5);
    chk("l3.d0.stat", 32'(O_capture_stat), 32'h04);
    I_data = 8'h5A; tick();
    chk_wr("l3.d1", C_DATA, 16'd0, 8'h5A);
    chk("l3.d1.done", 32'(O_done), 32'd0);
    I_data = 8'hFF; tick();
    chk_wr("l3.d2", C_DATA, 16'd0, 8'hFF);
    chk("l3.done", 32'(O_done), 32'd1);
    chk("l3.cap_off", 32'(O_capturing), 32'd0);
    I_data_valid = 1'b0; tick();
    chk("l3.nowr", 32'(O_capture_data_wr), 32'd0);
    I_arm = 1'b0; tick();
    chk("armfall.done", 32'(O_done), 32'd1);
    I_match = 1'b1; I_data_valid = 1'b1; tick();
    chk("done.ignore.wr", 32'(O_capture_data_wr), 32'd0);
    chk("done.ignore.done", 32'(O_done), 32'd1);
    I_match = 1'b0; I_data_valid = 1'b0;

    // Long gap -> TIME then DATA, with a follow-on byte queued.
    I_stat = 5'h01;
    I_arm = 1'b1; tick();
    chk("rearm.done", 32'(O_done), 32'd0);
    I_capture_len = 16'd0; I_match = 1'b1; tick();
    I_match = 1'b0; I_data_valid = 1'b1; I_data = 8'h11; tick();
    chk_wr("gap.d11", C_DATA, 16'd0, 8'h11);
    chk("gap.d11.stat", 32'(O_capture_stat), 32'h01);
    I_data_valid = 1'b0;
    idle_count(20, nwr);
    chk("gap.idle", 32'(nwr), 32'd0);
    I_data_valid = 1'b1; I_data = 8'h22; tick();
    chk_wr("gap.time", C_TIME, 16'd20, 8'h00);
    I_data = 8'h33; tick();
    chk_wr("gap.d22", C_DATA, 16'd0, 8'h22);
    I_data_valid = 1'b0; tick();
    chk_wr("gap.d33", C_DATA, 16'd0, 8'h33);
    tick();
    chk("gap.empty", 32'(O_capture_data_wr), 32'd0);
    repeat (3) tick();
    I_data_valid = 1'b1; I_data = 8'h44; tick();
    chk_wr("short.d44", C_DATA, 16'd5, 8'h44);

    // Timestamps disabled: no TIME, zero time field.
    I_data_valid = 1'b0; I_timestamps_disable = 1'b1;
    idle_count(10, nwr);
    chk("tsdis.idle", 32'(nwr), 32'd0);
    I_data_valid = 1'b1; I_data = 8'h55; tick();
    chk_wr("tsdis.d55", C_DATA, 16'd0, 8'h55);
    I_data_valid = 1'b0; I_timestamps_disable = 1'b0;

    // Status change without data, then a change absorbed by data.
    I_stat = 5'h03; tick();
`ifdef PW_STAT_EVENTS_EN
    chk_wr("stat.ev", C_STAT, 16'd0, 8'h00);
    chk("stat.val", 32'(O_capture_stat), 32'h03);
`else
    chk("stat.none", 32'(O_capture_data_wr), 32'd0);
`endif
    tick();
    chk("stat.steady", 32'(O_capture_data_wr), 32'd0);
    I_stat = 5'h07; I_data_valid = 1'b1; I_data = 8'h66; tick();
    chk("absorb.wr",   32'(O_capture_data_wr), 32'd1);
    chk("absorb.cmd",  32'(O_capture_cmd),     32'(C_DATA));
    chk("absorb.stat", 32'(O_capture_stat),    32'h07);
    I_data_valid = 1'b0; tick();
    chk("absorb.nostat", 32'(O_capture_data_wr), 32'd0);

    // FIFO full on bytes 2 and 4 of 5; len change after start is ignored.
    I_arm = 1'b0; tick();
    I_arm = 1'b1; tick();
    I_capture_len = 16'd5; I_match = 1'b1; tick();
    I_match = 1'b0; I_capture_len = 16'd2;
    nwr = 0;
    for (int i = 1; i <= 5; i++) begin
      I_data_valid = 1'b1; I_data = 8'(i); I_fifo_full = (i == 2 || i == 4);
      tick();
      nwr += int'(O_capture_data_wr);
      chk($sformatf("full.wr%0d", i), 32'(O_capture_data_wr), (i == 2 || i == 4) ? 32'd0 : 32'd1);
      if (i < 5) chk($sformatf("full.done%0d", i), 32'(O_done), 32'd0);
    end
    I_data_valid = 1'b0; I_fifo_full = 1'b0;
    chk("full.nwr",  32'(nwr),        32'd3);
    chk("full.ovf",  32'(O_overflow), 32'd1);
    chk("full.done", 32'(O_done),     32'd1);
    I_arm = 1'b0; tick();
    I_arm = 1'b1; tick();
    chk("rearm.ovfclr", 32'(O_overflow), 32'd0);

    // Long idle: one TIME with all-ones, then delta restarts.
    I_capture_len = 16'd0; I_match = 1'b1; tick();
    I_match = 1'b0;
    nwr = 0; at = 0; tsv = '0; cmdv = '0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (O_capture_data_wr) begin
        nwr++;
        if (at == 0) begin
          at = i; tsv = O_capture_time; cmdv = O_capture_cmd;
        end
      end
    end
    chk("wrap.count", 32'(nwr),  32'd1);
    chk("wrap.cycle", 32'(at),   32'd65536);
    chk("wrap.time",  32'(tsv),  32'hFFFF);
    chk("wrap.cmd",   32'(cmdv), 32'(C_TIME));
    I_data_valid = 1'b1; I_data = 8'h77; tick();
    chk_wr("wrap.restart", C_TIME, 16'd4464, 8'h00);
    I_data_valid = 1'b0; tick();
    chk_wr("wrap.d77", C_DATA, 16'd0, 8'h77);

    // Reset with an entry waiting in the skid queue.
    repeat (9) tick();
    I_data_valid = 1'b1; I_data = 8'h88; tick();
    chk_wr("rst2.time", C_TIME, 16'd10, 8'h00);
    I_data = 8'h99; tick();
    chk_wr("rst2.d88", C_DATA, 16'd0, 8'h88);
    reset_n = 1'b0;
    #1;
    chk("rst2.wr",   32'(O_capture_data_wr), 32'd0);
    chk("rst2.cap",  32'(O_capturing),       32'd0);
    chk("rst2.data", 32'(O_capture_data),    32'd0);
    chk("rst2.cmd",  32'(O_capture_cmd),     32'd0);
    I_match = 1'b1;
    @(negedge fe_clk) reset_n = 1'b1;
    nwr = 0; at = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nwr += int'(O_capture_data_wr);
      at  += int'(O_capturing);
    end
    chk("rst2.nowr",  32'(nwr), 32'd0);
    chk("rst2.idle",  32'(at),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
